// File: rtl/trace_pkg.sv
// Shared flag indices, FSM states, record layout and width helper for the
// cpu commit tracer.
package trace_pkg;

    localparam int FLG_R  = 0;
    localparam int FLG_L  = 1;
    localparam int FLG_S  = 2;
    localparam int FLG_H  = 3;
    localparam int FLAG_W = 4;

    localparam int REC_DATA_W = 16;
    localparam int REC_REG_AW = 4;
    localparam int REC_CNT_W  = 32;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_HALTED,
        S_TIMEOUT
    } traceState_e;

    // Field order matches the flat record the tracer packs into its FIFO.
    typedef struct packed {
        logic [FLAG_W-1:0]     flags;
        logic [REC_REG_AW-1:0] regIdx;
        logic [REC_DATA_W-1:0] rdata;
        logic [REC_DATA_W-1:0] maddr;
        logic [REC_DATA_W-1:0] mdata;
        logic [REC_CNT_W-1:0]  cycle;
    } traceRecord_t;

    function automatic int recordWidth(input int dataW, input int regAw, input int cntW);
        return FLAG_W + regAw + 3 * dataW + cntW;
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// First-word-fall-through record FIFO with extra-MSB pointers; a push into a
// full FIFO succeeds only when a pop happens in the same cycle.
module trace_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] pushData,
    input  logic             pop,
    output logic [WIDTH-1:0] popData,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wrPtr;
    logic [AW:0]      rdPtr;
    logic             doPush;
    logic             doPop;

    assign empty   = (wrPtr == rdPtr);
    assign full    = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
    assign doPop   = pop && !empty;
    assign doPush  = push && (!full || doPop);
    assign popData = mem[rdPtr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (doPush) begin
            mem[wrPtr[AW-1:0]] <= pushData;
        end
    end

    // Pointers wrap modulo 2*DEPTH so full and empty stay distinguishable.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wrPtr <= '0;
            rdPtr <= '0;
        end else begin
            if (doPush) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (doPop) begin
                rdPtr <= rdPtr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/cpu_commit_tracer.sv
// Commit monitor: stamps one record per retire cycle, queues it in a FIFO and
// drains it over valid/ready, with run counters, halt detection and a watchdog.
module cpu_commit_tracer
    import trace_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int REG_AW  = 4,
    parameter int DEPTH   = 16,
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 100000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              reg_we,
    input  logic [REG_AW-1:0] reg_dst,
    input  logic [DATA_W-1:0] reg_data,
    input  logic              mem_re,
    input  logic              mem_we,
    input  logic [DATA_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              halt,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [3:0]        out_flags,
    output logic [REG_AW-1:0] out_reg,
    output logic [DATA_W-1:0] out_rdata,
    output logic [DATA_W-1:0] out_maddr,
    output logic [DATA_W-1:0] out_mdata,
    output logic [CNT_W-1:0]  out_cycle,
    output logic [CNT_W-1:0]  cycle_cnt,
    output logic [CNT_W-1:0]  inst_cnt,
    output logic [CNT_W-1:0]  drop_cnt,
    output logic              overflow,
    output logic              timeout,
    output logic              done
);

    localparam int               REC_W   = recordWidth(DATA_W, REG_AW, CNT_W);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT - 1);

    traceState_e       state;
    logic [CNT_W-1:0]  cycleCnt;
    logic [CNT_W-1:0]  instCnt;
    logic [CNT_W-1:0]  dropCnt;
    logic              overflowFlag;
    logic              timeoutFlag;

    logic              running;
    logic              captureReq;
    logic              retireReq;
    logic              dropEvent;
    logic              fifoFull;
    logic              fifoEmpty;
    logic              fifoPop;
    logic [FLAG_W-1:0] capFlags;
    logic [DATA_W-1:0] capMdata;
    logic [REC_W-1:0]  pushRecord;
    logic [REC_W-1:0]  headRecord;

    logic [FLAG_W-1:0] headFlags;
    logic [REG_AW-1:0] headReg;
    logic [DATA_W-1:0] headRdata;
    logic [DATA_W-1:0] headMaddr;
    logic [DATA_W-1:0] headMdata;
    logic [CNT_W-1:0]  headCycle;

    assign running    = (state == S_RUN);
    assign captureReq = running && (reg_we || mem_re || mem_we || halt);
    assign retireReq  = running && (reg_we || mem_we || halt);
    assign fifoPop    = !fifoEmpty && out_ready;
    assign dropEvent  = captureReq && fifoFull && !fifoPop;

    // A store's data wins over load data if both strobes are ever seen together.
    always_comb begin
        capFlags        = '0;
        capFlags[FLG_R] = reg_we;
        capFlags[FLG_L] = mem_re;
        capFlags[FLG_S] = mem_we;
        capFlags[FLG_H] = halt;
        capMdata        = '0;
        if (mem_we) begin
            capMdata = mem_wdata;
        end else if (mem_re) begin
            capMdata = mem_rdata;
        end
    end

    assign pushRecord = {capFlags, reg_dst, reg_data, mem_addr, capMdata, cycleCnt};

    trace_fifo #(
        .WIDTH(REC_W),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (captureReq),
        .pushData(pushRecord),
        .pop     (fifoPop),
        .popData (headRecord),
        .full    (fifoFull),
        .empty   (fifoEmpty)
    );

    // Halt takes priority over the watchdog when both land on the same edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            cycleCnt     <= '0;
            instCnt      <= '0;
            dropCnt      <= '0;
            overflowFlag <= 1'b0;
            timeoutFlag  <= 1'b0;
        end else begin
            if (dropEvent) begin
                overflowFlag <= 1'b1;
                if (dropCnt != CNT_MAX) begin
                    dropCnt <= dropCnt + 1'b1;
                end
            end
            case (state)
                S_IDLE: begin
                    if (en) begin
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (cycleCnt != CNT_MAX) begin
                        cycleCnt <= cycleCnt + 1'b1;
                    end
                    if (retireReq && (instCnt != CNT_MAX)) begin
                        instCnt <= instCnt + 1'b1;
                    end
                    if (halt) begin
                        state <= S_HALTED;
                    end else if (cycleCnt == WD_LAST) begin
                        state       <= S_TIMEOUT;
                        timeoutFlag <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign {headFlags, headReg, headRdata, headMaddr, headMdata, headCycle} = headRecord;

    // Record fields read as zero whenever nothing is being offered.
    assign out_valid = !fifoEmpty;
    assign out_flags = out_valid ? headFlags : '0;
    assign out_reg   = out_valid ? headReg   : '0;
    assign out_rdata = out_valid ? headRdata : '0;
    assign out_maddr = out_valid ? headMaddr : '0;
    assign out_mdata = out_valid ? headMdata : '0;
    assign out_cycle = out_valid ? headCycle : '0;

    assign cycle_cnt = cycleCnt;
    assign inst_cnt  = instCnt;
    assign drop_cnt  = dropCnt;
    assign overflow  = overflowFlag;
    assign timeout   = timeoutFlag;
    assign done      = ((state == S_HALTED) || (state == S_TIMEOUT)) && fifoEmpty;

endmodule

// File: tb/tb_cpu_commit_tracer.sv
// Randomized and directed bench for cpu_commit_tracer against a queue-based
// reference model of the trace stream.
module tb_cpu_commit_tracer;
    import trace_pkg::*;

    localparam int DATA_W  = 16;
    localparam int REG_AW  = 4;
    localparam int DEPTH   = 16;
    localparam int CNT_W   = 32;
    localparam int TIMEOUT = 20;

    typedef enum {M_IDLE, M_RUN, M_HALTED, M_WATCHDOG} modelPhase_e;

    typedef struct {
        logic        rstN;
        logic        en;
        logic        regWe;
        logic [3:0]  regDst;
        logic [15:0] regData;
        logic        memRe;
        logic        memWe;
        logic [15:0] memAddr;
        logic [15:0] memWdata;
        logic [15:0] memRdata;
        logic        halt;
        logic        ready;
    } stim_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              en = 1'b0;
    logic              reg_we = 1'b0;
    logic [REG_AW-1:0] reg_dst = '0;
    logic [DATA_W-1:0] reg_data = '0;
    logic              mem_re = 1'b0;
    logic              mem_we = 1'b0;
    logic [DATA_W-1:0] mem_addr = '0;
    logic [DATA_W-1:0] mem_wdata = '0;
    logic [DATA_W-1:0] mem_rdata = '0;
    logic              halt = 1'b0;
    logic              out_ready = 1'b0;
    logic              out_valid;
    logic [3:0]        out_flags;
    logic [REG_AW-1:0] out_reg;
    logic [DATA_W-1:0] out_rdata;
    logic [DATA_W-1:0] out_maddr;
    logic [DATA_W-1:0] out_mdata;
    logic [CNT_W-1:0]  out_cycle;
    logic [CNT_W-1:0]  cycle_cnt;
    logic [CNT_W-1:0]  inst_cnt;
    logic [CNT_W-1:0]  drop_cnt;
    logic              overflow;
    logic              timeout;
    logic              done;

    always #5 clk = ~clk;

    cpu_commit_tracer #(
        .DATA_W (DATA_W),
        .REG_AW (REG_AW),
        .DEPTH  (DEPTH),
        .CNT_W  (CNT_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .reg_we   (reg_we),
        .reg_dst  (reg_dst),
        .reg_data (reg_data),
        .mem_re   (mem_re),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .halt     (halt),
        .out_ready(out_ready),
        .out_valid(out_valid),
        .out_flags(out_flags),
        .out_reg  (out_reg),
        .out_rdata(out_rdata),
        .out_maddr(out_maddr),
        .out_mdata(out_mdata),
        .out_cycle(out_cycle),
        .cycle_cnt(cycle_cnt),
        .inst_cnt (inst_cnt),
        .drop_cnt (drop_cnt),
        .overflow (overflow),
        .timeout  (timeout),
        .done     (done)
    );

    int           vectors = 0;
    int           miscompares = 0;
    traceRecord_t modelQ[$];
    modelPhase_e  mPhase = M_IDLE;
    longint       mCycle = 0;
    longint       mInst = 0;
    longint       mDrop = 0;
    bit           mOverflow = 1'b0;
    bit           mTimeout = 1'b0;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // The reference model: a record queue bounded at DEPTH plus run bookkeeping.
    function automatic void modelStep(input stim_t s);
        traceRecord_t r;
        if (!s.rstN) begin
            modelQ.delete();
            mPhase    = M_IDLE;
            mCycle    = 0;
            mInst     = 0;
            mDrop     = 0;
            mOverflow = 1'b0;
            mTimeout  = 1'b0;
            return;
        end
        if (modelQ.size() > 0 && s.ready) begin
            void'(modelQ.pop_front());
        end
        case (mPhase)
            M_IDLE: if (s.en) mPhase = M_RUN;
            M_RUN: begin
                if (s.regWe || s.memRe || s.memWe || s.halt) begin
                    r.flags  = {s.halt, s.memWe, s.memRe, s.regWe};
                    r.regIdx = s.regDst;
                    r.rdata  = s.regData;
                    r.maddr  = s.memAddr;
                    r.mdata  = s.memWe ? s.memWdata : (s.memRe ? s.memRdata : 16'h0);
                    r.cycle  = 32'(mCycle);
                    if (modelQ.size() < DEPTH) begin
                        modelQ.push_back(r);
                    end else begin
                        mDrop++;
                        mOverflow = 1'b1;
                    end
                end
                if (s.halt || s.regWe || s.memWe) mInst++;
                mCycle++;
                if (s.halt) begin
                    mPhase = M_HALTED;
                end else if (mCycle == TIMEOUT) begin
                    mPhase   = M_WATCHDOG;
                    mTimeout = 1'b1;
                end
            end
            default: ;
        endcase
    endfunction

    task automatic compareAll();
        traceRecord_t e;
        bit           v;
        v = (modelQ.size() > 0);
        e = '0;
        if (v) e = modelQ[0];
        checkOutput("out_valid", out_valid, v);
        checkOutput("out_flags", out_flags, e.flags);
        checkOutput("out_reg", out_reg, e.regIdx);
        checkOutput("out_rdata", out_rdata, e.rdata);
        checkOutput("out_maddr", out_maddr, e.maddr);
        checkOutput("out_mdata", out_mdata, e.mdata);
        checkOutput("out_cycle", out_cycle, e.cycle);
        checkOutput("cycle_cnt", cycle_cnt, mCycle);
        checkOutput("inst_cnt", inst_cnt, mInst);
        checkOutput("drop_cnt", drop_cnt, mDrop);
        checkOutput("overflow", overflow, mOverflow);
        checkOutput("timeout", timeout, mTimeout);
        checkOutput("done", done, (mPhase == M_HALTED || mPhase == M_WATCHDOG) && !v);
    endtask

    task automatic applyStimulus(input stim_t s);
        rst_n     = s.rstN;
        en        = s.en;
        reg_we    = s.regWe;
        reg_dst   = s.regDst;
        reg_data  = s.regData;
        mem_re    = s.memRe;
        mem_we    = s.memWe;
        mem_addr  = s.memAddr;
        mem_wdata = s.memWdata;
        mem_rdata = s.memRdata;
        halt      = s.halt;
        out_ready = s.ready;
        modelStep(s);
        @(posedge clk);
        #1;
        compareAll();
    endtask

    function automatic stim_t quiet(input bit ready);
        stim_t s;
        s.rstN = 1'b1;   s.en = 1'b0;       s.regWe = 1'b0;    s.regDst = '0;
        s.regData = '0;  s.memRe = 1'b0;    s.memWe = 1'b0;    s.memAddr = '0;
        s.memWdata = '0; s.memRdata = '0;   s.halt = 1'b0;     s.ready = ready;
        return s;
    endfunction

    function automatic stim_t randomStim();
        stim_t s;
        s          = quiet($urandom_range(0, 1) == 1);
        s.en       = ($urandom_range(0, 1) == 1);
        s.regWe    = ($urandom_range(0, 2) == 0);
        s.memRe    = ($urandom_range(0, 2) == 0);
        s.memWe    = ($urandom_range(0, 3) == 0);
        s.halt     = ($urandom_range(0, 24) == 0);
        s.regDst   = 4'($urandom);
        s.regData  = 16'($urandom);
        s.memAddr  = 16'($urandom);
        s.memWdata = 16'($urandom);
        s.memRdata = 16'($urandom);
        return s;
    endfunction

    task automatic resetAndStart();
        stim_t s;
        s      = quiet(1'b1);
        s.rstN = 1'b0;
        applyStimulus(s);
        s    = quiet(1'b1);
        s.en = 1'b1;
        applyStimulus(s);
    endtask

    initial begin
        stim_t s;

        // First capture: regwrite r3 in RUN cycle 0, held by a stalled consumer.
        resetAndStart();
        checkOutput("rst_cycle_cnt", cycle_cnt, 0);
        checkOutput("rst_valid", out_valid, 0);
        s = quiet(1'b0);
        s.en = 1'b1; s.regWe = 1'b1; s.regDst = 4'd3; s.regData = 16'h1234;
        applyStimulus(s);
        checkOutput("t1_valid", out_valid, 1);
        checkOutput("t1_flags", out_flags, 4'b0001);
        checkOutput("t1_reg", out_reg, 3);
        checkOutput("t1_rdata", out_rdata, 16'h1234);
        checkOutput("t1_cycle", out_cycle, 0);
        checkOutput("t1_inst", inst_cnt, 1);
        s = quiet(1'b0);
        applyStimulus(s);
        checkOutput("t1_hold", out_rdata, 16'h1234);

        // Store then load of the same word.
        s = quiet(1'b1);
        s.memWe = 1'b1; s.memAddr = 16'h0040; s.memWdata = 16'hBEEF;
        applyStimulus(s);
        checkOutput("st_flags", out_flags, 4'b0100);
        checkOutput("st_mdata", out_mdata, 16'hBEEF);
        s = quiet(1'b1);
        s.memRe = 1'b1; s.memAddr = 16'h0040; s.memRdata = 16'hBEEF;
        applyStimulus(s);
        checkOutput("ld_flags", out_flags, 4'b0010);
        checkOutput("ld_mdata", out_mdata, 16'hBEEF);
        checkOutput("ld_inst", inst_cnt, 2);

        // Overflow: DEPTH+3 captures with no consumer, then push alongside a pop.
        resetAndStart();
        for (int i = 0; i < DEPTH + 3; i++) begin
            s = quiet(1'b0);
            s.regWe = 1'b1; s.regDst = 4'(i); s.regData = 16'($urandom);
            applyStimulus(s);
        end
        checkOutput("ovf_drop", drop_cnt, 3);
        checkOutput("ovf_flag", overflow, 1);
        s = quiet(1'b1);
        s.regWe = 1'b1;
        applyStimulus(s);
        checkOutput("ovf_nodrop", drop_cnt, 3);
        checkOutput("ovf_head", out_cycle, 1);
        checkOutput("ovf_wd", timeout, 1);
        for (int i = 0; i < DEPTH + 4; i++) applyStimulus(quiet(1'b1));
        checkOutput("ovf_done", done, 1);

        // Halt together with a register write, then ignored activity.
        resetAndStart();
        s = quiet(1'b0);
        s.halt = 1'b1; s.regWe = 1'b1; s.regDst = 4'd7; s.regData = 16'h00AA;
        applyStimulus(s);
        checkOutput("halt_flags", out_flags, 4'b1001);
        for (int i = 0; i < 3; i++) begin
            s = quiet(1'b0);
            s.regWe = 1'b1; s.memWe = 1'b1;
            applyStimulus(s);
        end
        checkOutput("halt_inst", inst_cnt, 1);
        checkOutput("halt_notdone", done, 0);
        applyStimulus(quiet(1'b1));
        checkOutput("halt_done", done, 1);
        checkOutput("halt_empty", out_valid, 0);

        // Watchdog with no halt.
        resetAndStart();
        for (int i = 0; i < TIMEOUT - 1; i++) applyStimulus(quiet(1'b1));
        checkOutput("wd_early", timeout, 0);
        applyStimulus(quiet(1'b1));
        checkOutput("wd_fire", timeout, 1);
        checkOutput("wd_cycles", cycle_cnt, TIMEOUT);
        checkOutput("wd_done", done, 1);
        applyStimulus(quiet(1'b1));
        checkOutput("wd_frozen", cycle_cnt, TIMEOUT);

        // Halt on the last watchdog cycle beats the watchdog.
        resetAndStart();
        for (int i = 0; i < TIMEOUT - 1; i++) applyStimulus(quiet(1'b1));
        s = quiet(1'b0);
        s.halt = 1'b1;
        applyStimulus(s);
        checkOutput("hwd_timeout", timeout, 0);
        checkOutput("hwd_flags", out_flags, 4'b1000);
        checkOutput("hwd_cycle", out_cycle, TIMEOUT - 1);
        applyStimulus(quiet(1'b1));
        checkOutput("hwd_done", done, 1);
        checkOutput("hwd_timeout2", timeout, 0);

        // Reset mid-run with queued records.
        resetAndStart();
        for (int i = 0; i < 5; i++) begin
            s = quiet(1'b0);
            s.regWe = 1'b1; s.regData = 16'($urandom);
            applyStimulus(s);
        end
        s = quiet(1'b0);
        s.rstN = 1'b0; s.regWe = 1'b1;
        applyStimulus(s);
        checkOutput("mrst_valid", out_valid, 0);
        checkOutput("mrst_cycles", cycle_cnt, 0);
        checkOutput("mrst_inst", inst_cnt, 0);
        s = quiet(1'b0);
        s.en = 1'b1;
        applyStimulus(s);
        s = quiet(1'b0);
        s.regWe = 1'b1;
        applyStimulus(s);
        checkOutput("mrst_stamp", out_cycle, 0);

        // Randomized runs against the reference model.
        for (int run = 0; run < 12; run++) begin
            resetAndStart();
            for (int c = 0; c < TIMEOUT + 8; c++) applyStimulus(randomStim());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
